// File: rtl/sa_cache_fsm_pkg.sv
// Shared types and helpers for the set-associative cache controller.
package sa_cache_fsm_pkg;

    localparam int MAX_WAYS = 8;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } sa_state_t;

    // Bit width of an index over n items; never returns 0 so vectors stay legal.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sa_cache_way.sv
// One cache way: tag/valid/dirty flops with async reset plus an unreset line array.
module sa_cache_way #(
    parameter int TAG_W  = 22,
    parameter int IDX_W  = 6,
    parameter int LINE_W = 128,
    parameter int SETS   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_line_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              wr_dirty_i,
    input  logic [LINE_W-1:0] wr_line_i
);

    logic [TAG_W-1:0]  tag_q   [SETS];
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [LINE_W-1:0] data_q  [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                tag_q[s] <= '0;
            end
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            tag_q[wr_idx_i]   <= wr_tag_i;
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_idx_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/sa_cache_fsm.sv
// Set-associative write-back/write-allocate cache controller: FSM, victim choice,
// word merge, memory request registers and saturating hit/miss counters.
module sa_cache_fsm
    import sa_cache_fsm_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int SETS           = 64,
    parameter int WAYS           = 2,
    parameter int COUNT_W        = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cpu_req_valid,
    output logic                               cpu_req_ready,
    input  logic                               cpu_req_rw,
    input  logic [ADDR_W-1:0]                  cpu_req_addr,
    input  logic [WORD_W-1:0]                  cpu_req_wdata,
    input  logic [WORD_W/8-1:0]                cpu_req_be,
    output logic                               cpu_res_valid,
    output logic [WORD_W-1:0]                  cpu_res_rdata,
    output logic                               mem_req_valid,
    output logic                               mem_req_rw,
    output logic [ADDR_W-1:0]                  mem_req_addr,
    output logic [WORD_W*WORDS_PER_LINE-1:0]   mem_req_wdata,
    input  logic                               mem_resp_valid,
    input  logic [WORD_W*WORDS_PER_LINE-1:0]   mem_resp_rdata,
    output logic [COUNT_W-1:0]                 hit_count,
    output logic [COUNT_W-1:0]                 miss_count
);

    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int BYTES  = WORD_W / 8;
    localparam int WOFF_W = $clog2(BYTES);
    localparam int OFF_W  = $clog2(BYTES * WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = clog2_safe(WORDS_PER_LINE);
    localparam int WAY_W  = clog2_safe(WAYS);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    function automatic logic [WORD_W-1:0] merge_be(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [BYTES-1:0]  be);
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int b = 0; b < BYTES; b++) begin
            if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

    sa_state_t           state_q, state_d;
    logic                ready_q, ready_d;
    logic                req_rw_q, req_rw_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [WORD_W-1:0]   req_wdata_q, req_wdata_d;
    logic [BYTES-1:0]    req_be_q, req_be_d;
    logic                refill_q, refill_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [COUNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [COUNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [WAY_W-1:0]    rr_ptr_q [SETS];
    logic                rr_we;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WSEL_W-1:0]   word_sel;
    logic                unused_addr_bits;

    logic [WAYS-1:0]     way_valid, way_dirty, way_we;
    logic [TAG_W-1:0]    way_tag  [WAYS];
    logic [LINE_W-1:0]   way_line [WAYS];
    logic [TAG_W-1:0]    wr_tag;
    logic [LINE_W-1:0]   wr_line;
    logic                wr_dirty;

    logic                hit;
    logic [WAY_W-1:0]    hit_way, vict;
    logic [LINE_W-1:0]   hit_line, upd_line;
    logic [WORD_W-1:0]   sel_word;

    assign req_tag          = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx          = req_addr_q[OFF_W +: IDX_W];
    assign word_sel         = (WORDS_PER_LINE > 1) ? req_addr_q[WOFF_W +: WSEL_W] : '0;
    assign unused_addr_bits = ^req_addr_q[WOFF_W-1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        sa_cache_way #(
            .TAG_W  (TAG_W),
            .IDX_W  (IDX_W),
            .LINE_W (LINE_W),
            .SETS   (SETS)
        ) u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_idx_i   (req_idx),
            .rd_valid_o (way_valid[w]),
            .rd_dirty_o (way_dirty[w]),
            .rd_tag_o   (way_tag[w]),
            .rd_line_o  (way_line[w]),
            .wr_en_i    (way_we[w]),
            .wr_idx_i   (req_idx),
            .wr_tag_i   (wr_tag),
            .wr_dirty_i (wr_dirty),
            .wr_line_i  (wr_line)
        );
    end

    // Lookup: hit way, and victim = lowest invalid way else the set's round-robin pointer.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vict    = rr_ptr_q[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (way_valid[w] && (way_tag[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) vict = WAY_W'(w);
        end
        hit_line = way_line[hit_way];
        sel_word = hit_line[word_sel*WORD_W +: WORD_W];
        upd_line = hit_line;
        upd_line[word_sel*WORD_W +: WORD_W] = merge_be(sel_word, req_wdata_q, req_be_q);
    end

    always_comb begin
        state_d       = state_q;
        req_rw_d      = req_rw_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        req_be_d      = req_be_q;
        refill_d      = refill_q;
        victim_d      = victim_q;
        mem_valid_d   = mem_valid_q;
        mem_rw_d      = mem_rw_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        rr_we         = 1'b0;
        way_we        = '0;
        wr_tag        = req_tag;
        wr_line       = upd_line;
        wr_dirty      = 1'b0;
        cpu_res_valid = 1'b0;
        cpu_res_rdata = '0;

        case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    req_rw_d    = cpu_req_rw;
                    req_addr_d  = cpu_req_addr;
                    req_wdata_d = cpu_req_wdata;
                    req_be_d    = cpu_req_be;
                    refill_d    = 1'b0;
                    state_d     = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    cpu_res_valid = 1'b1;
                    if (req_rw_q) begin
                        way_we[hit_way] = 1'b1;
                        wr_dirty        = 1'b1;
                    end else begin
                        cpu_res_rdata = sel_word;
                    end
                    if (!refill_q) hit_cnt_d = sat_inc(hit_cnt_q);
                    state_d = IDLE;
                end else begin
                    if (!refill_q) miss_cnt_d = sat_inc(miss_cnt_q);
                    victim_d    = vict;
                    mem_valid_d = 1'b1;
                    if (way_valid[vict] && way_dirty[vict]) begin
                        mem_rw_d    = 1'b1;
                        mem_addr_d  = {way_tag[vict], req_idx, {OFF_W{1'b0}}};
                        mem_wdata_d = way_line[vict];
                        state_d     = WRITE_BACK;
                    end else begin
                        mem_rw_d    = 1'b0;
                        mem_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
                        state_d     = ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                if (mem_resp_valid) begin
                    mem_valid_d = 1'b0;
                    state_d     = ALLOCATE;
                end
            end
            ALLOCATE: begin
                // Arriving from WRITE_BACK the request is low; raise the fill one cycle later.
                if (!mem_valid_q) begin
                    mem_valid_d = 1'b1;
                    mem_rw_d    = 1'b0;
                    mem_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
                end else if (mem_resp_valid) begin
                    mem_valid_d      = 1'b0;
                    way_we[victim_q] = 1'b1;
                    wr_line          = mem_resp_rdata;
                    rr_we            = 1'b1;
                    refill_d         = 1'b1;
                    state_d          = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_d = (state_d == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            refill_q    <= 1'b0;
            victim_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            refill_q    <= refill_d;
            victim_q    <= victim_d;
            mem_valid_q <= mem_valid_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        req_rw_q    <= req_rw_d;
        req_addr_q  <= req_addr_d;
        req_wdata_q <= req_wdata_d;
        req_be_q    <= req_be_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr_q[s] <= '0;
            end
        end else if (rr_we) begin
            rr_ptr_q[req_idx] <= (victim_q == WAY_W'(WAYS - 1)) ? '0 : victim_q + WAY_W'(1);
        end
    end

    assign cpu_req_ready = ready_q;
    assign mem_req_valid = mem_valid_q;
    assign mem_req_rw    = mem_rw_q;
    assign mem_req_addr  = mem_addr_q;
    assign mem_req_wdata = mem_wdata_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_sa_cache_fsm.sv
// Bench for sa_cache_fsm: table of CPU accesses against a word-level memory model,
// plus hand sequences for write-back stalls, mid-fill reset and counter saturation.
module tb_sa_cache_fsm;

    localparam int LINE_W = 128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req_valid, cpu_req_ready, cpu_req_rw;
    logic [31:0]  cpu_req_addr, cpu_req_wdata;
    logic [3:0]   cpu_req_be;
    logic         cpu_res_valid;
    logic [31:0]  cpu_res_rdata;
    logic         mem_req_valid, mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [LINE_W-1:0] mem_req_wdata, mem_resp_rdata;
    logic         mem_resp_valid;
    logic [3:0]   hit_count, miss_count;

    always #5 clk = ~clk;

    sa_cache_fsm #(
        .ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(4), .SETS(64), .WAYS(2), .COUNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
        .cpu_res_valid(cpu_res_valid), .cpu_res_rdata(cpu_res_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          nreq;
        logic        rw0;
        logic [31:0] a0;
        int          hit;
        int          miss;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [LINE_W-1:0] wdata;
    } memreq_t;

    typedef struct {
        logic        rw;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    memreq_t     log_q[$];
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] cpu_view  [logic [31:0]];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hAAAA_AAAA;
            32'h0000_1004: return 32'hBBBB_BBBB;
            32'h0000_1008: return 32'hCCCC_CCCC;
            32'h0000_100C: return 32'hDDDD_DDDD;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rd_view(input logic [31:0] a);
        return cpu_view.exists(a) ? cpu_view[a] : dflt(a);
    endfunction

    function automatic logic [LINE_W-1:0] build_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = rd_mem(a + 32'(i * 4));
        return l;
    endfunction

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion pulse pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cpu_res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_res: got cpu_res_valid=1 expected no completion");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (!e.rw) check("res_rdata", 128'(cpu_res_rdata), 128'(e.rdata));
            end
        end
    end

    task automatic do_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input bit poke, output int nreq, output int lat);
        exp_t e;
        memreq_t m;
        logic [31:0] wa, w;
        int  seen;
        bit  done, poked, last_wb, wb_gap;
        log_q.delete();
        @(negedge clk);
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        cpu_req_be    = be;
        cpu_req_valid = 1'b1;
        check("req_ready", 128'(cpu_req_ready), 128'(1));
        wa = {addr[31:2], 2'b00};
        e.rw = rw;
        e.rdata = rd_view(wa);
        if (rw) begin
            w = rd_view(wa);
            for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
            cpu_view[wa] = w;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        lat = 0; seen = 0; done = 0; poked = 0; last_wb = 0; wb_gap = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (cpu_req_valid) cpu_req_valid = 1'b0;
            if (mem_resp_valid) begin
                mem_resp_valid = 1'b0;
                check("mem_req_drop", 128'(mem_req_valid), 128'(0));
                wb_gap = last_wb;
            end else begin
                if (wb_gap) begin
                    wb_gap = 0;
                    check("fill_after_wb", 128'({mem_req_valid, mem_req_rw}), 128'(2'b10));
                end
                if (mem_req_valid) begin
                    if (poke && !poked && mem_req_rw) begin
                        cpu_req_addr  = 32'h0000_2000;
                        cpu_req_rw    = 1'b0;
                        cpu_req_valid = 1'b1;
                        poked = 1;
                        check("ready_in_wb", 128'(cpu_req_ready), 128'(0));
                    end
                    seen++;
                    if (seen >= 2) begin
                        seen = 0;
                        m.rw = mem_req_rw; m.addr = mem_req_addr; m.wdata = mem_req_wdata;
                        log_q.push_back(m);
                        last_wb = mem_req_rw;
                        if (mem_req_rw) begin
                            for (int i = 0; i < 4; i++) mem_store[mem_req_addr + 32'(i * 4)] = mem_req_wdata[i*32 +: 32];
                            mem_resp_rdata = '0;
                        end else begin
                            mem_resp_rdata = build_line(mem_req_addr);
                        end
                        mem_resp_valid = 1'b1;
                    end
                end
            end
            if (cpu_res_valid) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout: addr 0x%0h got no completion in %0d cycles", addr, lat);
            mem_resp_valid = 1'b0;
        end
        nreq = log_q.size();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];
    int   nreq, lat, k;

    initial begin
        vecs[0] = '{0, 32'h1004, 0, 4'h0, 1, 0, 32'h1000, 0, 1};
        vecs[1] = '{0, 32'h1004, 0, 4'h0, 0, 0, 0,        1, 1};
        vecs[2] = '{1, 32'h1004, 32'h1234_5678, 4'b0011, 0, 0, 0, 2, 1};
        vecs[3] = '{0, 32'h1004, 0, 4'h0, 0, 0, 0,        3, 1};
        vecs[4] = '{0, 32'h1400, 0, 4'h0, 1, 0, 32'h1400, 3, 2};
        vecs[5] = '{0, 32'h1800, 0, 4'h0, 2, 1, 32'h1000, 3, 3};
        vecs[6] = '{0, 32'h1400, 0, 4'h0, 0, 0, 0,        4, 3};
        vecs[7] = '{0, 32'h100C, 0, 4'h0, 1, 0, 32'h1000, 4, 4};
        vecs[8] = '{0, 32'h1004, 0, 4'h0, 0, 0, 0,        5, 4};
        vecs[9] = '{1, 32'h1800, 32'hAABB_CCDD, 4'b1111, 0, 0, 0, 6, 4};

        rst_n = 1'b0;
        cpu_req_valid = 0; cpu_req_rw = 0; cpu_req_addr = 0; cpu_req_wdata = 0; cpu_req_be = 0;
        mem_resp_valid = 0; mem_resp_rdata = '0;

        #12;
        check("rst_ready", 128'(cpu_req_ready), 128'(0));
        check("rst_res_valid", 128'(cpu_res_valid), 128'(0));
        check("rst_rdata", 128'(cpu_res_rdata), 128'(0));
        check("rst_mem_valid", 128'(mem_req_valid), 128'(0));
        check("rst_mem_addr", 128'({mem_req_rw, mem_req_addr}), 128'(0));
        check("rst_counts", 128'({hit_count, miss_count}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge", 128'(cpu_req_ready), 128'(0));
        @(posedge clk);
        #1 check("ready_after_edge", 128'(cpu_req_ready), 128'(1));

        for (int i = 0; i < 10; i++) begin
            do_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, nreq, lat);
            check($sformatf("v%0d_nreq", i), 128'(nreq), 128'(vecs[i].nreq));
            if (nreq > 0 && vecs[i].nreq > 0)
                check($sformatf("v%0d_req0", i), 128'({log_q[0].rw, log_q[0].addr}), 128'({vecs[i].rw0, vecs[i].a0}));
            if (vecs[i].nreq == 0)
                check($sformatf("v%0d_hit_latency", i), 128'(lat), 128'(1));
            check($sformatf("v%0d_hit_count", i), 128'(hit_count), 128'(vecs[i].hit));
            check($sformatf("v%0d_miss_count", i), 128'(miss_count), 128'(vecs[i].miss));
            if (i == 5 && nreq == 2) begin
                check("wb_word1", 128'(log_q[0].wdata[63:32]), 128'(32'hBBBB_5678));
                check("fill_req", 128'({log_q[1].rw, log_q[1].addr}), 128'({1'b0, 32'h1800}));
            end
        end

        // Dirty victim 0x1800 is written back while a stray CPU request is presented.
        do_access(0, 32'h1C00, 0, 4'h0, 1, nreq, lat);
        check("poke_nreq", 128'(nreq), 128'(2));
        if (nreq == 2) begin
            check("poke_wb", 128'({log_q[0].rw, log_q[0].addr, log_q[0].wdata[31:0]}),
                  128'({1'b1, 32'h1800, 32'hAABB_CCDD}));
            check("poke_fill", 128'({log_q[1].rw, log_q[1].addr}), 128'({1'b0, 32'h1C00}));
        end
        repeat (4) @(negedge clk);
        check("poke_not_latched", 128'({cpu_req_ready, mem_req_valid}), 128'(2'b10));
        check("poke_counts", 128'({hit_count, miss_count}), 128'({4'd6, 4'd5}));

        // Reset asserted while the fill for 0x2000 is outstanding.
        @(negedge clk);
        cpu_req_rw = 0; cpu_req_addr = 32'h2000; cpu_req_valid = 1'b1;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        k = 0;
        while (!(mem_req_valid === 1'b1 && mem_req_rw === 1'b0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("alloc_reached", 128'(k < 50), 128'(1));
        rst_n = 1'b0;
        #1;
        check("arst_mem_valid", 128'(mem_req_valid), 128'(0));
        check("arst_res_valid", 128'(cpu_res_valid), 128'(0));
        check("arst_counts", 128'({hit_count, miss_count}), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cpu_view = mem_store;
        @(posedge clk);
        #1;
        do_access(0, 32'h1004, 0, 4'h0, 0, nreq, lat);
        check("post_rst_nreq", 128'(nreq), 128'(1));
        if (nreq == 1) check("post_rst_req", 128'({log_q[0].rw, log_q[0].addr}), 128'({1'b0, 32'h1000}));
        check("post_rst_counts", 128'({hit_count, miss_count}), 128'({4'd0, 4'd1}));

        for (int i = 0; i < 20; i++) do_access(0, 32'h1004, 0, 4'h0, 0, nreq, lat);
        check("sat_hit_count", 128'(hit_count), 128'(4'hF));
        check("sat_miss_count", 128'(miss_count), 128'(4'd1));
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
